// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm consumer path: FSM states, time packing
// and the fixed-priority alarm selector.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_e;

  localparam int TIME_W    = 24;
  localparam int ALARM_CNT = 3;

  // Packed BCD field positions inside a {hour, minute, second} time word
  localparam int HOUR_HI = 23;
  localparam int HOUR_LO = 16;
  localparam int MIN_HI  = 15;
  localparam int MIN_LO  = 8;
  localparam int SEC_HI  = 7;
  localparam int SEC_LO  = 0;

  // Lowest-numbered matching alarm wins; 0 means no match
  function automatic logic [1:0] pick_alarm(input logic [ALARM_CNT-1:0] hits);
    logic [1:0] id;
    id = 2'd0;
    if (hits[0])      id = 2'd1;
    else if (hits[1]) id = 2'd2;
    else if (hits[2]) id = 2'd3;
    return id;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave buzzer tone: toggles every TONE_DIV cycles while enabled, silent
// and reset to phase zero otherwise.
module alarm_tone_gen #(
  parameter int TONE_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic buzzer
);

  localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CW-1:0] TONE_LAST = CW'(TONE_DIV - 1);

  logic [CW-1:0] tone_cnt_q, tone_cnt_d;
  logic          buzz_q, buzz_d;

  always_comb begin
    tone_cnt_d = tone_cnt_q;
    buzz_d     = buzz_q;
    if (!en) begin
      tone_cnt_d = '0;
      buzz_d     = 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_d = '0;
      buzz_d     = ~buzz_q;
    end else begin
      tone_cnt_d = tone_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tone_cnt_q <= '0;
      buzz_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      buzz_q     <= buzz_d;
    end
  end

  // Gate with en so the pin drops in the same cycle ringing does
  assign buzzer = buzz_q & en;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm consumer: matches stored alarm times against the running clock each second
// and runs the ring / snooze / dismiss state machine driving the buzzer.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int TONE_DIV       = 50000,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sec_tick,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [TIME_W-1:0] alarm1_time,
  input  logic [TIME_W-1:0] alarm2_time,
  input  logic [TIME_W-1:0] alarm3_time,
  input  logic [2:0]        alarm_en,
  input  logic              dismiss,
  input  logic              snooze,
  output logic              ringing,
  output logic              snooze_active,
  output logic [1:0]        ring_id,
  output logic              buzzer
);

  localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam int SW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECONDS - 1);

  alarm_state_e     state_q, state_d;
  logic [1:0]       ring_id_q, ring_id_d;
  logic [RW-1:0]    ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]    snooze_cnt_q, snooze_cnt_d;
  logic             dismiss_q, snooze_q;
  logic             dismiss_e, snooze_e;
  logic [ALARM_CNT-1:0] hits;
  logic             id_en;

  assign dismiss_e = dismiss & ~dismiss_q;
  assign snooze_e  = snooze & ~snooze_q;

  assign hits[0] = alarm_en[0] && (cur_time == alarm1_time);
  assign hits[1] = alarm_en[1] && (cur_time == alarm2_time);
  assign hits[2] = alarm_en[2] && (cur_time == alarm3_time);

  // Enable bit of the alarm currently owning the ring/snooze cycle
  always_comb begin
    case (ring_id_q)
      2'd1:    id_en = alarm_en[0];
      2'd2:    id_en = alarm_en[1];
      2'd3:    id_en = alarm_en[2];
      default: id_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ring_id_d    = ring_id_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sec_tick && (hits != '0)) begin
          state_d    = ST_RING;
          ring_id_d  = pick_alarm(hits);
          ring_cnt_d = '0;
        end
      end
      ST_RING: begin
        if (!id_en || dismiss_e) begin
          state_d   = ST_IDLE;
          ring_id_d = 2'd0;
        end else if (snooze_e) begin
          state_d      = ST_SNOOZE;
          snooze_cnt_d = '0;
        end else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d   = ST_IDLE;
            ring_id_d = 2'd0;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (!id_en || dismiss_e) begin
          state_d   = ST_IDLE;
          ring_id_d = 2'd0;
        end else if (sec_tick) begin
          if (snooze_cnt_q == SNOOZE_LAST) begin
            state_d    = ST_RING;
            ring_cnt_d = '0;
          end else begin
            snooze_cnt_d = snooze_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ring_id_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ring_id_q    <= 2'd0;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      dismiss_q    <= 1'b0;
      snooze_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_id_q    <= ring_id_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      dismiss_q    <= dismiss;
      snooze_q     <= snooze;
    end
  end

  assign ringing       = (state_q == ST_RING);
  assign snooze_active = (state_q == ST_SNOOZE);
  assign ring_id       = ring_id_q;

  alarm_tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ringing),
    .buzzer  (buzzer)
  );

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed testbench for alarm_trigger with short tone, ring and snooze periods.
module tb_alarm_trigger;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sec_tick;
  logic [23:0] cur_time;
  logic [23:0] alarm1_time;
  logic [23:0] alarm2_time;
  logic [23:0] alarm3_time;
  logic [2:0]  alarm_en;
  logic        dismiss;
  logic        snooze;
  logic        ringing;
  logic        snooze_active;
  logic [1:0]  ring_id;
  logic        buzzer;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_trigger #(
    .TONE_DIV(4),
    .RING_SECONDS(3),
    .SNOOZE_SECONDS(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sec_tick      (sec_tick),
    .cur_time      (cur_time),
    .alarm1_time   (alarm1_time),
    .alarm2_time   (alarm2_time),
    .alarm3_time   (alarm3_time),
    .alarm_en      (alarm_en),
    .dismiss       (dismiss),
    .snooze        (snooze),
    .ringing       (ringing),
    .snooze_active (snooze_active),
    .ring_id       (ring_id),
    .buzzer        (buzzer)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; outputs are then stable for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL reset_ringing got %b want 0", ringing); end
    n_cmp++; if (snooze_active !== 1'b0) begin n_bad++; $display("FAIL reset_snooze got %b want 0", snooze_active); end
    n_cmp++; if (ring_id !== 2'd0) begin n_bad++; $display("FAIL reset_ring_id got %0d want 0", ring_id); end
    n_cmp++; if (buzzer !== 1'b0) begin n_bad++; $display("FAIL reset_buzzer got %b want 0", buzzer); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic_ring();
    alarm1_time = 24'h073000;
    alarm_en    = 3'b001;
    cur_time    = 24'h073000;
    tick();
    cur_time = 24'h073001;
    n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL basic_ringing got %b want 1", ringing); end
    n_cmp++; if (ring_id !== 2'd1) begin n_bad++; $display("FAIL basic_ring_id got %0d want 1", ring_id); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (buzzer !== 1'b0) begin n_bad++; $display("FAIL basic_buzz_low%0d got %b want 0", i, buzzer); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (buzzer !== 1'b1) begin n_bad++; $display("FAIL basic_buzz_high%0d got %b want 1", i, buzzer); end
    end
    step();
    n_cmp++; if (buzzer !== 1'b0) begin n_bad++; $display("FAIL basic_buzz_fall got %b want 0", buzzer); end
    dismiss = 1'b1;
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL basic_dismiss got %b want 0", ringing); end
    n_cmp++; if (ring_id !== 2'd0) begin n_bad++; $display("FAIL basic_dismiss_id got %0d want 0", ring_id); end
    dismiss = 1'b0;
    step();
  endtask

  task automatic test_auto_stop();
    cur_time = 24'h073000;
    tick();
    cur_time = 24'h073001;
    n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL auto_start got %b want 1", ringing); end
    for (int i = 0; i < 2; i++) begin
      step();
      tick();
      n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL auto_hold%0d got %b want 1", i, ringing); end
    end
    step();
    tick();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL auto_stop got %b want 0", ringing); end
    n_cmp++; if (ring_id !== 2'd0) begin n_bad++; $display("FAIL auto_stop_id got %0d want 0", ring_id); end
    n_cmp++; if (buzzer !== 1'b0) begin n_bad++; $display("FAIL auto_stop_buzz got %b want 0", buzzer); end
    step();
  endtask

  task automatic test_snooze();
    cur_time = 24'h073000;
    tick();
    cur_time = 24'h073001;
    snooze = 1'b1;
    step();
    n_cmp++; if (snooze_active !== 1'b1) begin n_bad++; $display("FAIL snz_active got %b want 1", snooze_active); end
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL snz_ringing got %b want 0", ringing); end
    n_cmp++; if (buzzer !== 1'b0) begin n_bad++; $display("FAIL snz_buzzer got %b want 0", buzzer); end
    n_cmp++; if (ring_id !== 2'd1) begin n_bad++; $display("FAIL snz_ring_id got %0d want 1", ring_id); end
    snooze = 1'b0;
    step();
    tick();
    n_cmp++; if (snooze_active !== 1'b1) begin n_bad++; $display("FAIL snz_hold got %b want 1", snooze_active); end
    step();
    tick();
    n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL snz_rering got %b want 1", ringing); end
    n_cmp++; if (snooze_active !== 1'b0) begin n_bad++; $display("FAIL snz_exit got %b want 0", snooze_active); end
    n_cmp++; if (ring_id !== 2'd1) begin n_bad++; $display("FAIL snz_rering_id got %0d want 1", ring_id); end
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL snz_dismiss got %b want 0", ringing); end
    step();
  endtask

  task automatic test_priority();
    alarm2_time = 24'h120000;
    alarm3_time = 24'h120000;
    alarm_en    = 3'b110;
    cur_time    = 24'h120000;
    tick();
    cur_time = 24'h120001;
    n_cmp++; if (ring_id !== 2'd2) begin n_bad++; $display("FAIL prio_ring_id got %0d want 2", ring_id); end
    dismiss = 1'b1;
    snooze  = 1'b1;
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL prio_both_ringing got %b want 0", ringing); end
    n_cmp++; if (snooze_active !== 1'b0) begin n_bad++; $display("FAIL prio_both_snooze got %b want 0", snooze_active); end
    n_cmp++; if (ring_id !== 2'd0) begin n_bad++; $display("FAIL prio_both_id got %0d want 0", ring_id); end
    dismiss = 1'b0;
    snooze  = 1'b0;
    step();
  endtask

  task automatic test_enable();
    alarm_en = 3'b000;
    cur_time = 24'h073000;
    tick();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL en_off_ringing got %b want 0", ringing); end
    alarm_en = 3'b001;
    tick();
    cur_time = 24'h073001;
    n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL en_on_ringing got %b want 1", ringing); end
    alarm_en = 3'b000;
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL en_clear_ringing got %b want 0", ringing); end
    n_cmp++; if (ring_id !== 2'd0) begin n_bad++; $display("FAIL en_clear_id got %0d want 0", ring_id); end
    alarm_en = 3'b001;
    step();
  endtask

  task automatic test_back_to_back();
    // Dismiss arriving together with the timeout tick
    cur_time = 24'h073000;
    tick();
    cur_time = 24'h073001;
    tick();
    tick();
    n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL b2b_before got %b want 1", ringing); end
    dismiss = 1'b1;
    tick();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL b2b_dismiss_tick got %b want 0", ringing); end
    n_cmp++; if (ring_id !== 2'd0) begin n_bad++; $display("FAIL b2b_id got %0d want 0", ring_id); end
    dismiss = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_ring();
    cur_time = 24'h073000;
    tick();
    cur_time = 24'h073001;
    step();
    step();
    step();
    step();
    n_cmp++; if (buzzer !== 1'b1) begin n_bad++; $display("FAIL rst_pre_buzz got %b want 1", buzzer); end
    reset_n = 1'b0;
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ringing got %b want 0", ringing); end
    n_cmp++; if (ring_id !== 2'd0) begin n_bad++; $display("FAIL rst_mid_id got %0d want 0", ring_id); end
    n_cmp++; if (buzzer !== 1'b0) begin n_bad++; $display("FAIL rst_mid_buzz got %b want 0", buzzer); end
    dismiss = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    cur_time = 24'h073000;
    tick();
    cur_time = 24'h073001;
    n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL rst_held_ring got %b want 1", ringing); end
    step();
    n_cmp++; if (ringing !== 1'b1) begin n_bad++; $display("FAIL rst_held_noact got %b want 1", ringing); end
    dismiss = 1'b0;
    step();
    dismiss = 1'b1;
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_bad++; $display("FAIL rst_new_edge got %b want 0", ringing); end
    dismiss = 1'b0;
    step();
  endtask

  initial begin
    reset_n     = 1'b0;
    sec_tick    = 1'b0;
    cur_time    = 24'h000000;
    alarm1_time = 24'h235959;
    alarm2_time = 24'h235959;
    alarm3_time = 24'h235959;
    alarm_en    = 3'b000;
    dismiss     = 1'b0;
    snooze      = 1'b0;
    #2;
    test_reset();
    test_basic_ring();
    test_auto_stop();
    test_snooze();
    test_priority();
    alarm2_time = 24'h235959;
    alarm3_time = 24'h235959;
    test_enable();
    test_back_to_back();
    test_reset_mid_ring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Consumer side of the alarm-setting path: reads the three stored alarm times (packed BCD hh:mm:ss) and compares them against the running clock once per second.
- Drives a ringing state machine with auto-timeout, snooze and dismiss, plus a square-wave buzzer output.
- Sits between the alarm-setting block, the timekeeping counter and the buzzer pin.
- Consumes debounced user buttons as levels.

Parameters:
- TONE_DIV, 50000: clk cycles per buzzer half-period; must be ≥2.
- RING_SECONDS, 60: seconds a ring lasts before auto-stop; must be ≥1.
- SNOOZE_SECONDS, 300: seconds in snooze before re-ring; must be ≥1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sec_tick  in  1  one-cycle pulse per second, coincident with the cur_time update
- cur_time  in  24  current time {hour[23:16], minute[15:8], second[7:0]}, packed BCD
- alarm1_time  in  24  alarm 1, same packing
- alarm2_time  in  24  alarm 2, same packing
- alarm3_time  in  24  alarm 3, same packing
- alarm_en  in  3  bit k-1 enables alarm k
- dismiss  in  1  debounced level; rising edge acts
- snooze  in  1  debounced level; rising edge acts
- ringing  out  1  high while in RING
- snooze_active  out  1  high while in SNOOZE
- ring_id  out  2  0 = none, 1..3 = active alarm
- buzzer  out  1  tone square wave, 0 when not ringing

Behaviour:
- Clock and reset: clk; reset_n synchronous, active-low.
- Reset values:
  - state = IDLE; ringing, snooze_active, ring_id, buzzer = 0.
  - ring_cnt, snooze_cnt, tone_cnt = 0.
  - Edge-detect registers = 0.
  - Reset has priority over every event, including mid-RING.
- Edge detect: dismiss_e = dismiss & ~dismiss_q and snooze_e = snooze & ~snooze_q, with _q registered every cycle.
- Match, computed on sec_tick cycles only:
  - match_k = alarm_en[k-1] && (cur_time == alarmk_time), compared as raw 24-bit equality with no BCD validation.
  - If several alarms match in the same cycle, the lowest k wins.
- States: IDLE, RING, SNOOZE.
- IDLE:
  - On sec_tick with any match → RING in the next cycle; ring_id = k, ring_cnt = 0, tone_cnt = 0.
  - dismiss_e and snooze_e are ignored.
- RING, events in priority order:
  1. alarm_en bit of ring_id cleared → IDLE, ring_id = 0.
  2. dismiss_e → IDLE, ring_id = 0.
  3. snooze_e → SNOOZE, snooze_cnt = 0, ring_id held.
  4. sec_tick with ring_cnt == RING_SECONDS-1 → IDLE, ring_id = 0.
  5. Otherwise, sec_tick → ring_cnt + 1.
  - New matches, including from other alarms, are ignored.
- SNOOZE, events in priority order:
  1. En bit cleared → IDLE.
  2. dismiss_e → IDLE.
  3. sec_tick with snooze_cnt == SNOOZE_SECONDS-1 → RING, ring_cnt = 0, tone_cnt = 0.
  4. Otherwise, sec_tick → snooze_cnt + 1.
  - snooze_e and matches are ignored.
- Latency:
  - Button edge registered in cycle t → state and outputs change at t+1.
  - Match on sec_tick at cycle t → ringing = 1 at t+1.
- Outputs are registered: ringing = (state == RING); snooze_active = (state == SNOOZE).
- Buzzer:
  - In RING: tone_cnt counts 0..TONE_DIV-1; at wrap, buzzer toggles and tone_cnt → 0. First toggle occurs TONE_DIV cycles after RING entry.
  - Outside RING: tone_cnt held at 0, buzzer = 0.
- Counter widths: $clog2 of the respective parameter, minimum 1; counters never exceed their terminal value.
- Boundary conditions:
  - dismiss_e and snooze_e in the same cycle → dismiss wins.
  - dismiss_e and the timeout tick in the same cycle → IDLE either way.
  - A button held through reset release produces no action in IDLE.

Decomposition:
- Package alarm_pkg:
  - state enum IDLE / RING / SNOOZE.
  - TIME_W = 24, ALARM_CNT = 3.
  - Field slice constants HOUR/MIN/SEC.
- One sub-module, alarm_tone_gen(TONE_DIV): inputs clk, reset_n, en; output buzzer. Holds tone_cnt and the toggle.

Test Plan:
- Basic ring: TONE_DIV=4, alarm1=24'h073000, en=3'b001, cur_time=24'h073000 with sec_tick → next cycle ringing=1, ring_id=1; buzzer rises 4 cycles later, period 8 cycles.
- Auto-stop: RING_SECONDS=3, no buttons → ringing drops the cycle after the 3rd sec_tick following entry; ring_id=0.
- Snooze and re-ring: SNOOZE_SECONDS=2, snooze rise during RING → snooze_active=1, buzzer=0; after 2 sec_ticks → ringing=1, ring_id unchanged.
- Priority: alarm2 = alarm3 = 24'h120000, en=3'b110 → ring_id=2; dismiss and snooze rising in the same cycle → IDLE, snooze_active=0.
- Enable control: en=0 with a matching time → no ring; clearing en[0] mid-RING of alarm 1 → ringing=0 next cycle.
- Reset: reset_n low mid-RING → all outputs 0 at the next edge; a dismiss level held across reset release has no effect.
